traffic_phase_ctrl: RTL and testbench
=====================================

# traffic_phase_ctrl

Parametrised N-approach traffic-light controller with demand-driven round-robin phasing, all-red clearance and a night flash mode. It is the next generation of the team's two-way fixed-cycle intersection controller and sits between the intersection sensor/button inputs and the lamp drivers. It includes its own 1 Hz tick prescaler for the 1 MHz system clock.

## Interface
- N_DIR, 4: number of approaches, 2..8, served in index order.
- TICK_DIV, 1_000_000: clk cycles per 1 s tick.
- GREEN_S, 30: minimum green time, in ticks.
- YELLOW_S, 5: yellow time, in ticks.
- ALLRED_S, 2: all-red clearance time, in ticks.
- CNT_W, 6: phase-counter width; must hold max(GREEN_S, YELLOW_S, ALLRED_S)-1.
- clk  in  1  system clock, 1 MHz.
- reset  in  1  synchronous, active-high reset. One clock domain only.
- req  in  N_DIR  per-approach demand (vehicle sensor or pedestrian button), sampled every clk.
- flash_mode  in  1  night mode request, level.
- red  out  N_DIR  red lamp per approach.
- yellow  out  N_DIR  yellow lamp per approach.
- green  out  N_DIR  green lamp per approach.
- active_dir  out  $clog2(N_DIR)  approach currently owning the phase.

## Operation
- States:
  - GREEN: green[active_dir]=1, all others red.
  - YELLOW: yellow[active_dir]=1, all others red.
  - ALLRED: all red.
  - FLASH: red[i]=flash_phase for all i; yellow and green all 0.
- Phase counter:
  - Loads duration-1 on entry to each state.
  - Decrements on each tick.
  - The state changes on the clk edge where tick=1 and count=0.
- Pending demand register, N_DIR bits:
  - Update each cycle: pending_next = (pending | req) & ~grant_mask.
  - grant_mask is one-hot for the approach entering GREEN in that cycle, otherwise 0. Clearing wins over a simultaneous req.
  - If req is still held, it re-latches on the following cycle.
- GREEN end (tick, count=0):
  - Any pending bit set other than active_dir: go to YELLOW.
  - No other pending bit set: stay in GREEN (rest on green) and reload GREEN_S-1.
- YELLOW end: go to ALLRED.
- ALLRED end:
  - flash_mode=1: go to FLASH.
  - Otherwise select the first pending index searching active_dir+1, active_dir+2, ... modulo N_DIR, excluding active_dir itself. If none is pending, use (active_dir+1) mod N_DIR.
  - Go to GREEN for the selected approach and update active_dir.
- flash_mode=1 in GREEN truncates green: go to YELLOW on the next tick, regardless of count.
  - YELLOW and ALLRED then run to full length before FLASH. flash_mode is not checked in YELLOW.
- FLASH:
  - flash_phase toggles every tick.
  - On a tick with flash_mode=0, go to ALLRED (full ALLRED_S), then select an approach as above.
- Counter arithmetic is unsigned CNT_W. No wrap is possible because reloads always happen at 0.

## Timing
- Reset values:
  - state=GREEN, active_dir=0, count=GREEN_S-1.
  - prescaler=0, pending=0, flash_phase=0.
  - Outputs: green=...0001, red=~green, yellow=0.
- Prescaler counts 0..TICK_DIV-1. tick is high for the one cycle where prescaler=TICK_DIV-1.
- Phase durations are exact tick multiples: GREEN_S×TICK_DIV, YELLOW_S×TICK_DIV and ALLRED_S×TICK_DIV cycles.
  - Exception: the first GREEN after reset is also GREEN_S×TICK_DIV cycles.
- Lamp outputs are combinational decodes of the registered state, active_dir and flash_phase. They change in the same cycle as the state register.
- Exactly one approach is non-red at a time, and no green ever follows green without YELLOW+ALLRED in between.
- Reset asserted mid-phase overrides everything on the next clk edge and returns all registers to their reset values.

## Structure
- Package traffic_pkg:
  - phase_t enum {GREEN, YELLOW, ALLRED, FLASH}.
  - Packed struct lamp_t {red, yellow, green}.
  - Default duration constants.
- Sub-module tick_prescaler(clk, reset, tick) with parameter TICK_DIV.
- Round-robin pick is a function in the controller.

## Test plan
Bench parameters: N_DIR=3, TICK_DIV=4, GREEN_S=3, YELLOW_S=2, ALLRED_S=1.

- Reset, no req for 40 cycles → green=001 throughout, active_dir=0, yellow=0.
- Pulse req=100 one cycle at cycle 5 → yellow=001 from cycle 12 to 19, all red 20–23, green=100 and active_dir=2 at cycle 24.
- req=110 held continuously from dir 0 green → order 0, 1, 2, 1, 2…; dir 0 is never re-granted while req[0]=0.
- flash_mode=1 asserted at cycle 5 in GREEN → YELLOW at cycle 8, ALLRED at 16, FLASH at 20, red toggles 111/000 every 4 cycles; deassert → ALLRED for 4 cycles, then GREEN.
- reset pulse during YELLOW → next cycle green=001, pending=0, count=2.
- req for an approach arriving in the same cycle that approach enters GREEN → pending bit cleared that cycle; no extra phase is served for it.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types and default timing for the traffic phase controller.
//   phase_t : controller phase (GREEN, YELLOW, ALLRED, FLASH)
//   lamp_t  : per-approach lamp triple {red, yellow, green}
//   DEF_*   : default parameter values (1 MHz clock, 1 s ticks)
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN,
    YELLOW,
    ALLRED,
    FLASH
  } phase_t;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

  localparam int unsigned DEF_N_DIR    = 4;
  localparam int unsigned DEF_TICK_DIV = 1_000_000;
  localparam int unsigned DEF_GREEN_S  = 30;
  localparam int unsigned DEF_YELLOW_S = 5;
  localparam int unsigned DEF_ALLRED_S = 2;
  localparam int unsigned DEF_CNT_W    = 6;

endpackage

// File: rtl/traffic_phase_ctrl_prescaler.sv
// tick_prescaler: divides clk down to a one-cycle tick every TICK_DIV cycles.
//   clk   : system clock
//   reset : synchronous, active-high; counter returns to 0
//   tick  : high for the single cycle where the counter equals TICK_DIV-1
module tick_prescaler
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: N-approach traffic-light controller with demand-driven
// round-robin phasing, all-red clearance and a night flash mode.
//   clk        : system clock (1 MHz nominal)
//   reset      : synchronous, active-high
//   req        : per-approach demand, sampled every clk
//   flash_mode : night flash request (level)
//   red/yellow/green : lamp drives, one bit per approach
//   active_dir : approach currently owning the phase
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned N_DIR    = DEF_N_DIR,
  parameter int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter int unsigned GREEN_S  = DEF_GREEN_S,
  parameter int unsigned YELLOW_S = DEF_YELLOW_S,
  parameter int unsigned ALLRED_S = DEF_ALLRED_S,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  localparam int unsigned DIR_W   = $clog2(N_DIR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_DIR-1:0] req,
  input  logic             flash_mode,
  output logic [N_DIR-1:0] red,
  output logic [N_DIR-1:0] yellow,
  output logic [N_DIR-1:0] green,
  output logic [DIR_W-1:0] active_dir
);

  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_S - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_S - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_S - 1);

  phase_t             state_q, state_d;
  logic [DIR_W-1:0]   dir_q, dir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_DIR-1:0]   pend_q, pend_d;
  logic               fphase_q, fphase_d;
  logic [N_DIR-1:0]   grant;
  logic [N_DIR-1:0]   dir_onehot;
  logic               others_pend;
  logic [DIR_W-1:0]   pick;
  logic               tick;
  lamp_t              lamp;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // First pending approach after cur (cyclic), never cur itself;
  // falls back to the next approach when nothing else is waiting.
  function automatic logic [DIR_W-1:0] rr_pick(input logic [N_DIR-1:0] pend,
                                               input logic [DIR_W-1:0] cur);
    logic [DIR_W-1:0] sel;
    logic             found;
    int unsigned      idx;
    idx   = (32'(cur) + 1) % N_DIR;
    sel   = idx[DIR_W-1:0];
    found = 1'b0;
    for (int unsigned k = 1; k < N_DIR; k++) begin
      idx = (32'(cur) + k) % N_DIR;
      if (!found && pend[idx[DIR_W-1:0]]) begin
        sel   = idx[DIR_W-1:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign dir_onehot  = N_DIR'(1) << dir_q;
  assign others_pend = |(pend_q & ~dir_onehot);
  assign pick        = rr_pick(pend_q, dir_q);

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    fphase_d = fphase_q;
    grant    = '0;
    if (tick) begin
      unique case (state_q)
        GREEN: begin
          // flash_mode cuts green short on any tick; otherwise leave only
          // when someone else is waiting, else rest on green.
          if (flash_mode || (cnt_q == '0 && others_pend)) begin
            state_d = YELLOW;
            cnt_d   = YELLOW_LD;
          end else if (cnt_q == '0) begin
            cnt_d = GREEN_LD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        YELLOW: begin
          if (cnt_q == '0) begin
            state_d = ALLRED;
            cnt_d   = ALLRED_LD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ALLRED: begin
          if (cnt_q == '0) begin
            if (flash_mode) begin
              state_d  = FLASH;
              fphase_d = 1'b0;
            end else begin
              state_d = GREEN;
              dir_d   = pick;
              cnt_d   = GREEN_LD;
              grant   = N_DIR'(1) << pick;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        FLASH: begin
          if (flash_mode) begin
            fphase_d = ~fphase_q;
          end else begin
            state_d  = ALLRED;
            cnt_d    = ALLRED_LD;
            fphase_d = 1'b0;
          end
        end
      endcase
    end
    // The grant clears the bit even if req is asserted in the same cycle.
    pend_d = (pend_q | req) & ~grant;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= GREEN;
      dir_q    <= '0;
      cnt_q    <= GREEN_LD;
      pend_q   <= '0;
      fphase_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      fphase_q <= fphase_d;
    end
  end

  always_comb begin
    red    = '0;
    yellow = '0;
    green  = '0;
    lamp   = '{red: 1'b1, yellow: 1'b0, green: 1'b0};
    for (int unsigned i = 0; i < N_DIR; i++) begin
      lamp = '{red: 1'b1, yellow: 1'b0, green: 1'b0};
      unique case (state_q)
        GREEN:  if (dir_q == i[DIR_W-1:0]) lamp = '{red: 1'b0, yellow: 1'b0, green: 1'b1};
        YELLOW: if (dir_q == i[DIR_W-1:0]) lamp = '{red: 1'b0, yellow: 1'b1, green: 1'b0};
        ALLRED: lamp = '{red: 1'b1, yellow: 1'b0, green: 1'b0};
        FLASH:  lamp = '{red: fphase_q, yellow: 1'b0, green: 1'b0};
      endcase
      red[i]    = lamp.red;
      yellow[i] = lamp.yellow;
      green[i]  = lamp.green;
    end
  end

  assign active_dir = dir_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
module tb_traffic_phase_ctrl;

  localparam int N  = 3;
  localparam int TD = 4;
  localparam int GS = 3;
  localparam int YS = 2;
  localparam int AS = 1;

  localparam int PG = 0;
  localparam int PY = 1;
  localparam int PA = 2;
  localparam int PF = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] req = '0;
  logic       flash_mode = 1'b0;
  logic [2:0] red, yellow, green;
  logic [1:0] active_dir;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Behavioural reference: remaining whole ticks per phase, bit vector of waiting approaches.
  int         m_pre, m_ph, m_left, m_dir;
  bit         m_fp;
  logic [2:0] m_pend;
  logic [2:0] e_red, e_yel, e_grn;
  logic [1:0] e_dir;

  traffic_phase_ctrl #(
    .N_DIR   (3),
    .TICK_DIV(4),
    .GREEN_S (3),
    .YELLOW_S(2),
    .ALLRED_S(1),
    .CNT_W   (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .flash_mode(flash_mode),
    .red       (red),
    .yellow    (yellow),
    .green     (green),
    .active_dir(active_dir)
  );

  always #5 clk = ~clk;

  task automatic model_outputs();
    e_grn = (m_ph == PG) ? (3'b001 << m_dir) : 3'b000;
    e_yel = (m_ph == PY) ? (3'b001 << m_dir) : 3'b000;
    e_red = (m_ph == PF) ? {3{m_fp}} : ~(e_grn | e_yel);
    e_dir = 2'(m_dir);
  endtask

  task automatic model_reset();
    m_pre = 0; m_ph = PG; m_left = GS; m_dir = 0; m_fp = 1'b0; m_pend = '0;
    model_outputs();
  endtask

  task automatic model_edge(input logic [2:0] r, input logic f);
    bit         tk;
    bit         others;
    int         sel;
    logic [2:0] grant;
    tk     = (m_pre == TD - 1);
    m_pre  = (m_pre + 1) % TD;
    grant  = '0;
    others = 1'b0;
    for (int i = 0; i < N; i++) if (i != m_dir && m_pend[i]) others = 1'b1;
    if (tk) begin
      if (m_ph == PG) begin
        m_left--;
        if (f || (m_left == 0 && others)) begin m_ph = PY; m_left = YS; end
        else if (m_left == 0) m_left = GS;
      end else if (m_ph == PY) begin
        m_left--;
        if (m_left == 0) begin m_ph = PA; m_left = AS; end
      end else if (m_ph == PA) begin
        m_left--;
        if (m_left == 0) begin
          if (f) begin
            m_ph = PF; m_fp = 1'b0;
          end else begin
            sel = (m_dir + 1) % N;
            for (int k = N - 1; k >= 1; k--) if (m_pend[(m_dir + k) % N]) sel = (m_dir + k) % N;
            m_dir = sel; grant = 3'b001 << sel; m_ph = PG; m_left = GS;
          end
        end
      end else begin
        if (f) m_fp = ~m_fp;
        else begin m_ph = PA; m_left = AS; m_fp = 1'b0; end
      end
    end
    m_pend = (m_pend | r) & ~grant;
    model_outputs();
  endtask

  // Drive one cycle of inputs, advance one clock, leave time 1 unit after the edge.
  task automatic step(input logic [2:0] r, input logic f, input logic rst);
    req = r; flash_mode = f; reset = rst;
    @(posedge clk);
    if (rst) begin model_reset(); cyc = 0; end
    else begin model_edge(r, f); cyc++; end
    #1;
  endtask

  task automatic test_reset();
    step(3'b000, 1'b0, 1'b1);
    n_cmp++;
    if ({red, yellow, green, active_dir} !== {3'b110, 3'b000, 3'b001, 2'd0}) begin
      n_bad++;
      $display("FAIL reset_state got r=%b y=%b g=%b d=%0d want r=110 y=000 g=001 d=0",
               red, yellow, green, active_dir);
    end
    for (int k = 0; k < 40; k++) begin
      step(3'b000, 1'b0, 1'b0);
      n_cmp++;
      if ({yellow, green, active_dir} !== {3'b000, 3'b001, 2'd0}) begin
        n_bad++;
        $display("FAIL idle_rest cyc=%0d got y=%b g=%b d=%0d want y=000 g=001 d=0",
                 cyc, yellow, green, active_dir);
      end
    end
  endtask

  task automatic test_single_req();
    logic [2:0] er, ey, eg;
    step(3'b000, 1'b0, 1'b1);
    for (int k = 0; k < 28; k++) begin
      step((k == 5) ? 3'b100 : 3'b000, 1'b0, 1'b0);
      if (cyc < 12)      begin er = 3'b110; ey = 3'b000; eg = 3'b001; end
      else if (cyc < 20) begin er = 3'b110; ey = 3'b001; eg = 3'b000; end
      else if (cyc < 24) begin er = 3'b111; ey = 3'b000; eg = 3'b000; end
      else               begin er = 3'b011; ey = 3'b000; eg = 3'b100; end
      n_cmp++;
      if ({red, yellow, green} !== {er, ey, eg}) begin
        n_bad++;
        $display("FAIL single_req cyc=%0d got r=%b y=%b g=%b want r=%b y=%b g=%b",
                 cyc, red, yellow, green, er, ey, eg);
      end
      if (cyc == 24) begin
        n_cmp++;
        if (active_dir !== 2'd2) begin
          n_bad++;
          $display("FAIL single_req_dir got %0d want 2", active_dir);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] prev_g;
    int         onsets;
    int         want;
    step(3'b000, 1'b0, 1'b1);
    prev_g = green;
    onsets = 0;
    for (int k = 0; k < 200; k++) begin
      step(3'b110, 1'b0, 1'b0);
      n_cmp++;
      if ({red, yellow, green, active_dir} !== {e_red, e_yel, e_grn, e_dir}) begin
        n_bad++;
        $display("FAIL rr_model cyc=%0d got r=%b y=%b g=%b d=%0d want r=%b y=%b g=%b d=%0d",
                 cyc, red, yellow, green, active_dir, e_red, e_yel, e_grn, e_dir);
      end
      if (prev_g == 3'b000 && green != 3'b000) begin
        want = (onsets % 2 == 0) ? 1 : 2;
        onsets++;
        n_cmp++;
        if (active_dir !== 2'(want) || green[0] !== 1'b0) begin
          n_bad++;
          $display("FAIL rr_order onset=%0d got d=%0d g=%b want d=%0d", onsets, active_dir, green, want);
        end
      end
      prev_g = green;
    end
    n_cmp++;
    if (onsets != 8) begin
      n_bad++;
      $display("FAIL rr_onsets got %0d want 8", onsets);
    end
  endtask

  task automatic test_flash();
    logic [2:0] er, ey, eg;
    step(3'b000, 1'b0, 1'b1);
    for (int k = 0; k < 45; k++) begin
      step(3'b000, (k >= 5 && k < 33), 1'b0);
      if (cyc < 8)       begin er = 3'b110; ey = 3'b000; eg = 3'b001; end
      else if (cyc < 16) begin er = 3'b110; ey = 3'b001; eg = 3'b000; end
      else if (cyc < 20) begin er = 3'b111; ey = 3'b000; eg = 3'b000; end
      else if (cyc < 36) begin er = (((cyc - 20) / 4) % 2 == 1) ? 3'b111 : 3'b000; ey = '0; eg = '0; end
      else if (cyc < 40) begin er = 3'b111; ey = 3'b000; eg = 3'b000; end
      else               begin er = 3'b101; ey = 3'b000; eg = 3'b010; end
      n_cmp++;
      if ({red, yellow, green} !== {er, ey, eg}) begin
        n_bad++;
        $display("FAIL flash cyc=%0d got r=%b y=%b g=%b want r=%b y=%b g=%b",
                 cyc, red, yellow, green, er, ey, eg);
      end
    end
    n_cmp++;
    if (active_dir !== 2'd1) begin
      n_bad++;
      $display("FAIL flash_exit_dir got %0d want 1", active_dir);
    end
  endtask

  task automatic test_reset_mid();
    for (int pass = 0; pass < 2; pass++) begin
      step(3'b000, 1'b0, 1'b1);
      for (int k = 0; k < 14; k++) step((k == 0) ? 3'b100 : (k == 12) ? 3'b010 : 3'b000, 1'b0, 1'b0);
      n_cmp++;
      if (yellow !== 3'b001) begin
        n_bad++;
        $display("FAIL mid_setup got y=%b want 001", yellow);
      end
      step(3'b000, 1'b0, 1'b1);
      n_cmp++;
      if ({red, yellow, green, active_dir} !== {3'b110, 3'b000, 3'b001, 2'd0}) begin
        n_bad++;
        $display("FAIL mid_reset got r=%b y=%b g=%b d=%0d want r=110 y=000 g=001 d=0",
                 red, yellow, green, active_dir);
      end
      for (int k = 0; k < 40; k++) begin
        step((pass == 1 && k == 0) ? 3'b010 : 3'b000, 1'b0, 1'b0);
        if (pass == 0 || cyc < 12) begin
          n_cmp++;
          if (green !== 3'b001 || yellow !== 3'b000) begin
            n_bad++;
            $display("FAIL mid_after cyc=%0d got y=%b g=%b want y=000 g=001", cyc, yellow, green);
          end
        end else if (cyc < 20) begin
          n_cmp++;
          if (yellow !== 3'b001) begin
            n_bad++;
            $display("FAIL mid_count cyc=%0d got y=%b want 001", cyc, yellow);
          end
        end
      end
    end
  endtask

  task automatic test_same_cycle_grant();
    step(3'b000, 1'b0, 1'b1);
    for (int k = 0; k < 100; k++) begin
      step((k == 0) ? 3'b010 : (k == 23) ? 3'b110 : 3'b000, 1'b0, 1'b0);
      if (cyc >= 24 && cyc < 36) begin
        n_cmp++;
        if (green !== 3'b010) begin
          n_bad++;
          $display("FAIL grant_g1 cyc=%0d got g=%b want 010", cyc, green);
        end
      end else if (cyc >= 48) begin
        n_cmp++;
        if (green !== 3'b100 || yellow !== 3'b000) begin
          n_bad++;
          $display("FAIL grant_clear cyc=%0d got y=%b g=%b want y=000 g=100", cyc, yellow, green);
        end
      end
    end
  endtask

  task automatic test_random();
    logic       f;
    logic [2:0] r;
    logic       rst;
    f = 1'b0;
    step(3'b000, 1'b0, 1'b1);
    for (int k = 0; k < 2500; k++) begin
      r   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      if ($urandom_range(0, 299) == 0) f = ~f;
      rst = ($urandom_range(0, 999) == 0);
      step(r, f, rst);
      n_cmp++;
      if ({red, yellow, green, active_dir} !== {e_red, e_yel, e_grn, e_dir}) begin
        n_bad++;
        $display("FAIL random cyc=%0d got r=%b y=%b g=%b d=%0d want r=%b y=%b g=%b d=%0d",
                 cyc, red, yellow, green, active_dir, e_red, e_yel, e_grn, e_dir);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_req();
    test_round_robin();
    test_flash();
    test_reset_mid();
    test_same_cycle_grant();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
